// File: rtl/mem_pkg.sv
// Shared SRAM geometry for the switch memory subsystem.
package mem_pkg;

  localparam int ADDR_W     = 10;
  localparam int BLOCK_BITS = 32;

endpackage

// File: rtl/switch_pkg.sv
// Common switch-core types.
package switch_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } wrr_state_e;

endpackage

// File: rtl/rr_pick.sv
// Rotating first-set search: returns the first set bit of mask at or after
// ptr (wrapping modulo N) as a one-hot vector and as an index.
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Walk the N candidate positions starting at ptr; the first hit wins.
  always_comb begin
    int k;
    logic [IW-1:0] kk;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    k      = 0;
    kk     = '0;
    for (int i = 0; i < N; i++) begin
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      kk = IW'(k);
      if (!any && mask[kk]) begin
        any        = 1'b1;
        onehot[kk] = 1'b1;
        idx        = kk;
      end
    end
  end

endmodule

// File: rtl/wrr_burst_arbiter.sv
// Weighted round-robin N-to-1 write arbiter with burst lock, burst length cap
// and idle-lock timeout, feeding the shared SRAM write port.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | arbitrate among eligible ports with credit, reload if none
//   LOCK  | owner holds the port for a multi-beat burst
module wrr_burst_arbiter
  import switch_pkg::*;
#(
  parameter  int NUM_PORTS = 4,
  parameter  int ADDR_W    = mem_pkg::ADDR_W,
  parameter  int DATA_W    = mem_pkg::BLOCK_BITS,
  parameter  int WEIGHT_W  = 4,
  parameter  int MAX_BURST = 8,
  parameter  int STALL_MAX = 15,
  localparam int IW        = $clog2(NUM_PORTS)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_PORTS-1:0]               req_i,
  input  logic [NUM_PORTS-1:0]               last_i,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0]   addr_i,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0]   wdata_i,
  input  logic [NUM_PORTS-1:0][WEIGHT_W-1:0] weight_i,
  output logic [NUM_PORTS-1:0]               gnt_o,
  output logic                               mem_we_o,
  output logic [ADDR_W-1:0]                  mem_waddr_o,
  output logic [DATA_W-1:0]                  mem_wdata_o,
  output logic [IW-1:0]                      grant_port_o,
  output logic                               locked_o
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int SW = $clog2(STALL_MAX + 1);
  localparam bit SINGLE_BEAT = (MAX_BURST == 1);

  wrr_state_e state, state_nxt;
  logic [IW-1:0] owner, owner_nxt;
  logic [IW-1:0] rr_ptr, rr_nxt;
  logic [NUM_PORTS-1:0][WEIGHT_W-1:0] credit, credit_nxt;
  logic [BW-1:0] beat_cnt, beat_nxt;
  logic [SW-1:0] stall_cnt, stall_nxt;

  logic [NUM_PORTS-1:0] wnz, has_cred, cred_nz, pick_mask, pick_oh, gnt;
  logic [IW-1:0] pick_idx, rel_port, xfer_idx;
  logic pick_any, reload, rel;

  // Eligibility and credit reload; reloaded credits are arbitrated on at once.
  always_comb begin
    wnz      = '0;
    has_cred = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      wnz[p]      = (weight_i[p] != '0);
      has_cred[p] = (credit[p] != '0);
    end
    reload    = (state == IDLE) && (|(req_i & wnz)) && !(|(req_i & wnz & has_cred));
    cred_nz   = reload ? wnz : has_cred;
    pick_mask = (state == IDLE) ? (req_i & wnz & cred_nz) : '0;
  end

  rr_pick #(.N(NUM_PORTS)) u_pick (
    .mask   (pick_mask),
    .ptr    (rr_ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Next-state, grant and release decision.
  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    rr_nxt     = rr_ptr;
    credit_nxt = credit;
    beat_nxt   = beat_cnt;
    stall_nxt  = stall_cnt;
    gnt        = '0;
    rel        = 1'b0;
    rel_port   = owner;
    unique case (state)
      IDLE: begin
        if (reload) credit_nxt = weight_i;
        if (pick_any) begin
          gnt = pick_oh;
          if (last_i[pick_idx] || SINGLE_BEAT) begin
            rel      = 1'b1;
            rel_port = pick_idx;
          end else begin
            state_nxt = LOCK;
            owner_nxt = pick_idx;
            beat_nxt  = BW'(1);
            stall_nxt = '0;
          end
        end
      end
      LOCK: begin
        if (req_i[owner]) begin
          gnt[owner] = 1'b1;
          stall_nxt  = '0;
          beat_nxt   = beat_cnt + BW'(1);
          if (last_i[owner] || beat_nxt == BW'(MAX_BURST)) rel = 1'b1;
        end else begin
          stall_nxt = stall_cnt + SW'(1);
          if (stall_nxt == SW'(STALL_MAX)) rel = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (rel) begin
      if (credit_nxt[rel_port] != '0)
        credit_nxt[rel_port] = credit_nxt[rel_port] - WEIGHT_W'(1);
      rr_nxt    = (rel_port == IW'(NUM_PORTS - 1)) ? '0 : rel_port + IW'(1);
      state_nxt = IDLE;
      beat_nxt  = '0;
      stall_nxt = '0;
    end
  end

  // Grants are suppressed while reset is held.
  assign gnt_o    = rst ? '0 : gnt;
  assign locked_o = (state == LOCK);
  assign xfer_idx = (state == LOCK) ? owner : pick_idx;

  // Arbitration state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      credit    <= '0;
      beat_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      rr_ptr    <= rr_nxt;
      credit    <= credit_nxt;
      beat_cnt  <= beat_nxt;
      stall_cnt <= stall_nxt;
    end
  end

  // Register the transferred beat onto the SRAM write port; data holds when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we_o     <= 1'b0;
      mem_waddr_o  <= '0;
      mem_wdata_o  <= '0;
      grant_port_o <= '0;
    end else begin
      mem_we_o <= |gnt;
      if (|gnt) begin
        mem_waddr_o  <= addr_i[xfer_idx];
        mem_wdata_o  <= wdata_i[xfer_idx];
        grant_port_o <= xfer_idx;
      end
    end
  end

  a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_o));
  a_gnt_req:    assert property (@(posedge clk) disable iff (rst) (gnt_o & ~req_i) == '0);
  a_gnt_weight: assert property (@(posedge clk) disable iff (rst)
                                 (state == IDLE) |-> ((gnt_o & ~wnz) == '0));

endmodule

// File: tb/tb_wrr_burst_arbiter.sv
// Directed bench for wrr_burst_arbiter: requester model drives beats, expected
// writes go into a scoreboard queue, a monitor checks every SRAM write.
module tb_wrr_burst_arbiter;

  localparam int NP = 4;
  localparam int AW = mem_pkg::ADDR_W;
  localparam int DW = mem_pkg::BLOCK_BITS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NP-1:0]         req_i = '0;
  logic [NP-1:0]         last_i = '0;
  logic [NP-1:0][AW-1:0] addr_i = '0;
  logic [NP-1:0][DW-1:0] wdata_i = '0;
  logic [NP-1:0][3:0]    weight_i = '0;
  logic [NP-1:0]         gnt_o;
  logic                  mem_we_o;
  logic [AW-1:0]         mem_waddr_o;
  logic [DW-1:0]         mem_wdata_o;
  logic [1:0]            grant_port_o;
  logic                  locked_o;

  wrr_burst_arbiter dut (
    .clk(clk), .rst(rst), .req_i(req_i), .last_i(last_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .weight_i(weight_i), .gnt_o(gnt_o), .mem_we_o(mem_we_o),
    .mem_waddr_o(mem_waddr_o), .mem_wdata_o(mem_wdata_o),
    .grant_port_o(grant_port_o), .locked_o(locked_o)
  );

  always #5 clk = ~clk;

  typedef struct { int port; int beat; } exp_t;
  exp_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  int rem[NP], bnum[NP], blen[NP];
  bit hold[NP];
  logic [NP-1:0] last_gnt;
  logic last_locked;
  int xfer_cnt;
  int lk;

  function automatic logic [AW-1:0] addr_of(int p, int b);
    return AW'(p * 32 + b);
  endfunction

  function automatic logic [DW-1:0] data_of(int p, int b);
    return DW'(32'hA500_0000 + p * 256 + b);
  endfunction

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic void push(int p, int b);
    exp_t e;
    e.port = p;
    e.beat = b;
    exp_q.push_back(e);
  endfunction

  function automatic void drive();
    for (int p = 0; p < NP; p++) begin
      req_i[p]   = (rem[p] > 0) && !hold[p];
      addr_i[p]  = addr_of(p, bnum[p]);
      wdata_i[p] = data_of(p, bnum[p]);
      last_i[p]  = (blen[p] == 0) ? 1'b0 : ((bnum[p] % blen[p]) == blen[p] - 1);
    end
  endfunction

  // Scoreboard monitor: every SRAM write must match the next expected beat.
  always @(negedge clk) begin
    if (!rst && mem_we_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: port %0d addr %0h, expected no write",
                 grant_port_o, mem_waddr_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wr_port", 64'(grant_port_o), 64'(e.port));
        chk("wr_addr", 64'(mem_waddr_o), 64'(addr_of(e.port, e.beat)));
        chk("wr_data", 64'(mem_wdata_o), 64'(data_of(e.port, e.beat)));
      end
    end
  end

  task automatic step();
    logic [NP-1:0] x;
    @(negedge clk);
    x           = req_i & gnt_o;
    last_gnt    = x;
    last_locked = locked_o;
    if (x != '0) xfer_cnt++;
    @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++)
      if (x[p]) begin
        bnum[p]++;
        rem[p]--;
      end
    drive();
  endtask

  task automatic drain(string name);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
    chk({"drain_", name}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int p = 0; p < NP; p++) begin
      rem[p]  = 0;
      bnum[p] = 0;
      blen[p] = 1;
      hold[p] = 1'b0;
    end
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    xfer_cnt = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    for (int p = 0; p < NP; p++) begin
      rem[p] = 0; bnum[p] = 0; blen[p] = 1; hold[p] = 1'b0;
    end
    drive();

    // Reset state
    @(posedge clk); #1;
    chk("rst_we", 64'(mem_we_o), 64'd0);
    chk("rst_addr", 64'(mem_waddr_o), 64'd0);
    chk("rst_data", 64'(mem_wdata_o), 64'd0);
    chk("rst_port", 64'(grant_port_o), 64'd0);
    chk("rst_locked", 64'(locked_o), 64'd0);
    chk("rst_gnt", 64'(gnt_o), 64'd0);

    // Equal weights, single beats: 0,1,2,3,0,1,2,3 back to back
    do_reset();
    weight_i = {4'd1, 4'd1, 4'd1, 4'd1};
    for (int p = 0; p < NP; p++) rem[p] = 2;
    drive();
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < NP; p++) push(p, r);
    repeat (8) step();
    chk("equal_no_bubble", 64'(xfer_cnt), 64'd8);
    drain("equal");

    // Weights {3,1,0,1}: 0,1,3,0,0 per round, port2 never
    do_reset();
    weight_i[0] = 4'd3; weight_i[1] = 4'd1; weight_i[2] = 4'd0; weight_i[3] = 4'd1;
    rem[0] = 6; rem[1] = 2; rem[2] = 3; rem[3] = 2;
    drive();
    push(0, 0); push(1, 0); push(3, 0); push(0, 1); push(0, 2);
    push(1, 1); push(3, 1); push(0, 3); push(0, 4); push(0, 5);
    repeat (10) step();
    chk("weighted_no_bubble", 64'(xfer_cnt), 64'd10);
    drain("weighted");
    chk("weight0_req", 64'(req_i), 64'b0100);
    chk("weight0_gnt", 64'(gnt_o), 64'd0);

    // Burst lock: port2 5 beats, port0 waits
    do_reset();
    weight_i = {4'd1, 4'd1, 4'd1, 4'd1};
    rem[2] = 5; blen[2] = 5;
    drive();
    for (int b = 0; b < 5; b++) push(2, b);
    push(0, 0);
    step();
    chk("burst_first_gnt", 64'(last_gnt), 64'b0100);
    chk("burst_first_locked", 64'(last_locked), 64'd0);
    rem[0] = 1; blen[0] = 1;
    drive();
    lk = 0;
    repeat (4) begin
      step();
      if (last_locked && last_gnt == 4'b0100) lk++;
    end
    chk("burst_locked_beats", 64'(lk), 64'd4);
    step();
    chk("burst_then_p0", 64'(last_gnt), 64'b0001);
    chk("burst_unlocked", 64'(last_locked), 64'd0);
    drain("burst");

    // Burst cap: port1 12 beats without last, port3 gets in after 8
    do_reset();
    weight_i = {4'd1, 4'd1, 4'd1, 4'd1};
    rem[1] = 12; blen[1] = 0;
    drive();
    for (int b = 0; b < 8; b++) push(1, b);
    push(3, 0);
    for (int b = 8; b < 12; b++) push(1, b);
    step();
    rem[3] = 1; blen[3] = 1;
    drive();
    lk = 0;
    repeat (7) begin
      step();
      if (last_locked && last_gnt == 4'b0010) lk++;
    end
    chk("cap_locked_beats", 64'(lk), 64'd7);
    step();
    chk("cap_other_gnt", 64'(last_gnt), 64'b1000);
    chk("cap_released", 64'(last_locked), 64'd0);
    step();
    chk("cap_resume_gnt", 64'(last_gnt), 64'b0010);
    repeat (3) step();
    drain("cap");

    // Stall timeout: 14 idle cycles keep the lock, 15 release it
    do_reset();
    weight_i = {4'd1, 4'd1, 4'd1, 4'd1};
    rem[3] = 4; blen[3] = 0;
    drive();
    push(3, 0); push(3, 1); push(3, 2); push(0, 0);
    step();
    rem[0] = 1; blen[0] = 1;
    drive();
    step();
    chk("stall_lock_gnt", 64'(last_gnt), 64'b1000);
    hold[3] = 1'b1; drive(); xfer_cnt = 0; lk = 0;
    repeat (14) begin
      step();
      if (last_locked) lk++;
    end
    chk("stall14_xfers", 64'(xfer_cnt), 64'd0);
    chk("stall14_locked", 64'(lk), 64'd14);
    hold[3] = 1'b0; drive();
    step();
    chk("stall14_resume_gnt", 64'(last_gnt), 64'b1000);
    chk("stall14_resume_locked", 64'(last_locked), 64'd1);
    hold[3] = 1'b1; drive(); xfer_cnt = 0; lk = 0;
    repeat (15) begin
      step();
      if (last_locked) lk++;
    end
    chk("stall15_xfers", 64'(xfer_cnt), 64'd0);
    chk("stall15_locked", 64'(lk), 64'd15);
    step();
    chk("stall15_p0_gnt", 64'(last_gnt), 64'b0001);
    chk("stall15_unlocked", 64'(last_locked), 64'd0);
    drain("stall");

    // Reset mid-burst: port1 locked with beat 3 pending
    do_reset();
    weight_i = {4'd1, 4'd1, 4'd1, 4'd1};
    rem[1] = 8; blen[1] = 0;
    drive();
    push(1, 0); push(1, 1);
    step();
    step();
    @(negedge clk);
    chk("midrst_locked_before", 64'(locked_o), 64'd1);
    chk("midrst_gnt_before", 64'(gnt_o), 64'b0010);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_gnt", 64'(gnt_o), 64'd0);
    chk("midrst_locked", 64'(locked_o), 64'd0);
    chk("midrst_we", 64'(mem_we_o), 64'd0);
    @(posedge clk); #1;
    chk("midrst_we_edge", 64'(mem_we_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_queue", 64'(exp_q.size()), 64'd0);
    rem[1] = 1; blen[1] = 1;
    rem[0] = 1; blen[0] = 1;
    drive();
    push(0, 0); push(1, 2);
    step();
    chk("restart_first_gnt", 64'(last_gnt), 64'b0001);
    step();
    chk("restart_second_gnt", 64'(last_gnt), 64'b0010);
    drain("restart");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
